// File: rtl/lsu.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned bus
// transactions with byte strobes, returns extended load data and reports faults.
module lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ren,
   input  logic        i_wen,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_stall,
   output logic        o_fault,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_strb,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_err
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        we_q, we_d;
   logic [3:0]  strb_q, strb_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic [15:0] cnt_q, cnt_d;
   logic        fault_q, fault_d;

   logic        access, size_ok, misalign, bad;
   logic [31:0] st_wdata, shifted, ld_ext;
   logic [3:0]  st_strb;

   always_comb begin
      access   = i_ren | i_wen;
      size_ok  = i_wen ? (i_funct3 inside {3'b000, 3'b001, 3'b010})
                       : (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
      bad      = (i_ren & i_wen) | ~size_ok | misalign;
   end

   always_comb begin
      st_wdata = i_wdata;
      st_strb  = 4'b1111;
      case (i_funct3[1:0])
         2'b00: begin
            st_wdata = {4{i_wdata[7:0]}};
            st_strb  = 4'b0001 << i_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{i_wdata[15:0]}};
            st_strb  = 4'b0011 << i_addr[1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = i_bus_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ld_ext = {24'd0, shifted[7:0]};
         3'b101:  ld_ext = {16'd0, shifted[15:0]};
         default: ld_ext = shifted;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      strb_d  = strb_q;
      off_d   = off_q;
      f3_d    = f3_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               rdata_d = '0;
               if (bad) begin
                  state_d = RESP;
                  fault_d = 1'b1;
               end else begin
                  state_d = BUS;
                  fault_d = 1'b0;
                  addr_d  = {i_addr[31:2], 2'b00};
                  we_d    = i_wen;
                  wdata_d = i_wen ? st_wdata : '0;
                  strb_d  = i_wen ? st_strb : '0;
                  off_d   = i_addr[1:0];
                  f3_d    = i_funct3;
                  cnt_d   = '0;
               end
            end
         end
         BUS: begin
            cnt_d = cnt_q + 16'd1;
            // an ack in the final timeout cycle still completes normally
            if (i_bus_ack) begin
               state_d = RESP;
               fault_d = i_bus_err;
               rdata_d = (!we_q && !i_bus_err) ? ld_ext : '0;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               state_d = RESP;
               fault_d = 1'b1;
               rdata_d = '0;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         strb_q  <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         strb_q  <= strb_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      o_stall     = (state_q == BUS) || ((state_q == IDLE) && access);
      o_bus_req   = (state_q == BUS);
      o_bus_we    = o_bus_req & we_q;
      o_bus_addr  = o_bus_req ? addr_q : '0;
      o_bus_wdata = o_bus_req ? wdata_q : '0;
      o_bus_strb  = o_bus_req ? strb_q : '0;
      o_fault     = (state_q == RESP) & fault_q;
      o_rdata     = (state_q == RESP) ? rdata_q : '0;
   end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a short bus timeout.
module tb_lsu;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_ren = 1'b0, i_wen = 1'b0;
   logic [2:0]  i_funct3 = '0;
   logic [31:0] i_addr = '0, i_wdata = '0;
   logic [31:0] o_rdata;
   logic        o_stall, o_fault, o_bus_req, o_bus_we;
   logic [31:0] o_bus_addr, o_bus_wdata;
   logic [3:0]  o_bus_strb;
   logic        i_bus_ack = 1'b0, i_bus_err = 1'b0;
   logic [31:0] i_bus_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   int          r_stalls, r_reqs;
   logic        r_fault, r_we;
   logic [31:0] r_rdata, r_addr, r_wdata;
   logic [3:0]  r_strb;

   lsu #(.TIMEOUT(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_ren(i_ren), .i_wen(i_wen),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_rdata(o_rdata), .o_stall(o_stall), .o_fault(o_fault),
      .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
      .o_bus_wdata(o_bus_wdata), .o_bus_strb(o_bus_strb),
      .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Drives one access from IDLE until the RESP cycle, acking on BUS cycle ack_at
   // (0 = never), then steps back to IDLE.
   task automatic run(input logic ren, input logic wen, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                      input logic [31:0] rd, input logic err);
      logic done = 1'b0;
      int   bus_cyc = 0;
      i_ren = ren; i_wen = wen; i_funct3 = f3; i_addr = a; i_wdata = wd;
      r_stalls = 0; r_reqs = 0; r_fault = 1'b0; r_rdata = '0;
      r_addr = '0; r_we = 1'b0; r_strb = '0; r_wdata = '0;
      #1;
      for (int c = 0; c < 20 && !done; c++) begin
         if (o_bus_req) begin
            r_reqs++; bus_cyc++;
            r_addr = o_bus_addr; r_we = o_bus_we; r_strb = o_bus_strb; r_wdata = o_bus_wdata;
            if (bus_cyc == ack_at) begin
               i_bus_ack = 1'b1; i_bus_rdata = rd; i_bus_err = err;
            end
         end
         if (o_stall) r_stalls++;
         else begin
            done = 1'b1; r_fault = o_fault; r_rdata = o_rdata;
         end
         if (!done) begin
            step();
            i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0;
            i_ren = 1'b0; i_wen = 1'b0;
            if (o_stall) begin i_ren = ren; i_wen = wen; end
         end
      end
      i_ren = 1'b0; i_wen = 1'b0;
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL access_complete: stall never dropped, required completion within 20 cycles");
      end
      step();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      step(); step();
      i_rst = 1'b0;
      #1;
      n_checks++;
      if ({o_stall, o_bus_req, o_fault, o_bus_we} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {o_stall, o_bus_req, o_fault, o_bus_we});
      end
      n_checks++;
      if ({o_rdata, o_bus_addr, o_bus_wdata, o_bus_strb} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h %h %h %h required all 0", o_rdata, o_bus_addr, o_bus_wdata, o_bus_strb);
      end
   endtask

   task automatic test_store_word();
      run(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, '0, 1'b0);
      n_checks++;
      if (r_addr !== 32'h100 || r_strb !== 4'b1111 || r_we !== 1'b1 || r_wdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL sw_bus: got addr=%h strb=%b we=%b wdata=%h required 100 1111 1 deadbeef", r_addr, r_strb, r_we, r_wdata);
      end
      n_checks++;
      if (r_stalls !== 3 || r_reqs !== 2) begin
         n_fail++; $display("FAIL sw_latency: got stalls=%0d reqs=%0d required 3 2", r_stalls, r_reqs);
      end
      n_checks++;
      if (r_fault !== 1'b0 || r_rdata !== 32'h0) begin
         n_fail++; $display("FAIL sw_resp: got fault=%b rdata=%h required 0 0", r_fault, r_rdata);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
      logic [31:0] ad [5]  = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200};
      logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011, 32'h80112233};
      for (int i = 0; i < 5; i++) begin
         run(1'b1, 1'b0, f3[i], ad[i], '0, 1, 32'h80112233, 1'b0);
         n_checks++;
         if (r_rdata !== exp[i] || r_fault !== 1'b0) begin
            n_fail++; $display("FAIL load_%0d: got rdata=%h fault=%b required %h 0", i, r_rdata, r_fault, exp[i]);
         end
         n_checks++;
         if (r_addr !== 32'h200 || r_we !== 1'b0 || r_strb !== 4'b0000 || r_stalls !== 2) begin
            n_fail++; $display("FAIL load_bus_%0d: got addr=%h we=%b strb=%b stalls=%0d required 200 0 0000 2", i, r_addr, r_we, r_strb, r_stalls);
         end
      end
   endtask

   task automatic test_store_lanes();
      run(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000A5, 1, '0, 1'b0);
      n_checks++;
      if (r_wdata !== 32'hA5A5A5A5 || r_strb !== 4'b0010 || r_addr !== 32'h10) begin
         n_fail++; $display("FAIL sb_lane: got wdata=%h strb=%b addr=%h required a5a5a5a5 0010 10", r_wdata, r_strb, r_addr);
      end
      run(1'b0, 1'b1, 3'b001, 32'h12, 32'h00001234, 1, '0, 1'b0);
      n_checks++;
      if (r_wdata !== 32'h12341234 || r_strb !== 4'b1100 || r_addr !== 32'h10) begin
         n_fail++; $display("FAIL sh_lane: got wdata=%h strb=%b addr=%h required 12341234 1100 10", r_wdata, r_strb, r_addr);
      end
   endtask

   task automatic test_bad_access();
      logic        ren [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic        wen [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  f3  [4] = '{3'b010, 3'b010, 3'b011, 3'b100};
      logic [31:0] ad  [4] = '{32'h101, 32'h100, 32'h100, 32'h100};
      for (int i = 0; i < 4; i++) begin
         run(ren[i], wen[i], f3[i], ad[i], 32'h55, 1, 32'hFFFFFFFF, 1'b0);
         n_checks++;
         if (r_fault !== 1'b1 || r_reqs !== 0 || r_stalls !== 1 || r_rdata !== 32'h0) begin
            n_fail++; $display("FAIL bad_%0d: got fault=%b reqs=%0d stalls=%0d rdata=%h required 1 0 1 0", i, r_fault, r_reqs, r_stalls, r_rdata);
         end
      end
   endtask

   task automatic test_timeout_err();
      run(1'b1, 1'b0, 3'b010, 32'h300, '0, 0, '0, 1'b0);
      n_checks++;
      if (r_fault !== 1'b1 || r_reqs !== 4 || r_stalls !== 5) begin
         n_fail++; $display("FAIL timeout: got fault=%b reqs=%0d stalls=%0d required 1 4 5", r_fault, r_reqs, r_stalls);
      end
      run(1'b1, 1'b0, 3'b010, 32'h300, '0, 2, 32'h12345678, 1'b1);
      n_checks++;
      if (r_fault !== 1'b1 || r_rdata !== 32'h0) begin
         n_fail++; $display("FAIL bus_err: got fault=%b rdata=%h required 1 0", r_fault, r_rdata);
      end
      run(1'b1, 1'b0, 3'b010, 32'h300, '0, 4, 32'hCAFEF00D, 1'b0);
      n_checks++;
      if (r_fault !== 1'b0 || r_rdata !== 32'hCAFEF00D || r_reqs !== 4) begin
         n_fail++; $display("FAIL ack_last_cycle: got fault=%b rdata=%h reqs=%0d required 0 cafef00d 4", r_fault, r_rdata, r_reqs);
      end
   endtask

   task automatic test_reset_mid_bus();
      i_ren = 1'b1; i_funct3 = 3'b010; i_addr = 32'h400;
      step();
      n_checks++;
      if (o_bus_req !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_bus: got req=%b required 1", o_bus_req);
      end
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      #1;
      n_checks++;
      if (o_bus_req !== 1'b0 || o_stall !== 1'b1) begin
         n_fail++; $display("FAIL rst_idle_held: got req=%b stall=%b required 0 1", o_bus_req, o_stall);
      end
      i_ren = 1'b0;
      i_bus_ack = 1'b1; i_bus_rdata = 32'hBAD0BAD0;
      #1;
      n_checks++;
      if (o_stall !== 1'b0 || o_fault !== 1'b0) begin
         n_fail++; $display("FAIL rst_idle_free: got stall=%b fault=%b required 0 0", o_stall, o_fault);
      end
      step();
      i_bus_ack = 1'b0; i_bus_rdata = '0;
      n_checks++;
      if ({o_stall, o_bus_req, o_fault} !== 3'b000 || o_rdata !== 32'h0) begin
         n_fail++; $display("FAIL late_ack_ignored: got stall/req/fault=%b rdata=%h required 000 0", {o_stall, o_bus_req, o_fault}, o_rdata);
      end
      run(1'b1, 1'b0, 3'b010, 32'h404, '0, 1, 32'h0BADF00D, 1'b0);
      n_checks++;
      if (r_rdata !== 32'h0BADF00D || r_fault !== 1'b0 || r_addr !== 32'h404 || r_stalls !== 2) begin
         n_fail++; $display("FAIL post_rst_lw: got rdata=%h fault=%b addr=%h stalls=%0d required 0badf00d 0 404 2", r_rdata, r_fault, r_addr, r_stalls);
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_loads();
      test_store_lanes();
      test_bad_access();
      test_timeout_err();
      test_reset_mid_bus();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
